// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer:
// 2-bit direction counter type, its constants and saturating step functions.
package btb_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_ALLOC = 2'b10;
    localparam ctr_t CTR_MAX   = 2'b11;
    localparam ctr_t CTR_MIN   = 2'b00;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_MAX) ? c : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_MIN) ? c : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/tag/counter/target storage with a lookup
// read port and an update read/write port. Valid bits and counters are reset.
module btb_way
    import btb_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned SETS  = 64,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_match,
    output ctr_t             rd_ctr,
    output logic [PC_W-1:0]  rd_target,
    input  logic [IDX_W-1:0] up_idx,
    input  logic [TAG_W-1:0] up_tag,
    output logic             up_match,
    output logic             up_valid,
    output ctr_t             up_ctr,
    input  logic             alloc,
    input  logic             ctr_we,
    input  ctr_t             ctr_wdata,
    input  logic             tgt_we,
    input  logic [PC_W-1:0]  tgt_wdata
);

    logic [SETS-1:0]        valid_q, valid_d;
    ctr_t [SETS-1:0]        ctr_q, ctr_d;
    logic [TAG_W-1:0]       tag_q    [SETS];
    logic [TAG_W-1:0]       tag_d    [SETS];
    logic [PC_W-1:0]        target_q [SETS];
    logic [PC_W-1:0]        target_d [SETS];

    assign rd_match  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign up_valid  = valid_q[up_idx];
    assign up_match  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr    = ctr_q[up_idx];

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (alloc) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                ctr_d[up_idx]    = CTR_ALLOC;
                target_d[up_idx] = tgt_wdata;
            end
            if (ctr_we) ctr_d[up_idx] = ctr_wdata;
            if (tgt_we) target_d[up_idx] = tgt_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ctr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target storage carry no reset; valid_q gates their use.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB top: combinational lookup, update/allocation with
// invalid-first then round-robin victims, flush. `BTB_FWD_EN enables
// same-cycle update-to-lookup forwarding for an identical aligned PC.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned PC_W = 32,
    parameter int unsigned SETS = 64,
    parameter int unsigned WAYS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [PC_W-1:0] pc_in,
    output logic            hit,
    output logic [PC_W-1:0] target_predict,
    output logic            predict_taken,
    input  logic            br_update,
    input  logic            br_taken,
    input  logic [PC_W-1:0] pc_ex,
    input  logic [PC_W-1:0] target_pc
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [IDX_W-1:0] rd_idx, up_idx;
    logic [TAG_W-1:0] rd_tag, up_tag;
    logic [WAYS-1:0]  rd_match, up_match, up_valid, alloc, ctr_we, tgt_we;
    ctr_t             rd_ctr    [WAYS];
    ctr_t             up_ctr    [WAYS];
    logic [PC_W-1:0]  rd_target [WAYS];
    logic             up_ok, up_any;
    ctr_t             hit_ctr, new_ctr;
    logic [PTR_W-1:0] victim;
    logic             found_inv;

    logic [SETS-1:0][PTR_W-1:0] ptr_q, ptr_d;

    assign rd_idx = pc_in[IDX_W+1:2];
    assign rd_tag = pc_in[PC_W-1:IDX_W+2];
    assign up_idx = pc_ex[IDX_W+1:2];
    assign up_tag = pc_ex[PC_W-1:IDX_W+2];
    assign up_ok  = br_update && !flush && (pc_ex[1:0] == 2'b00);
    assign up_any = |up_match;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way #(
            .PC_W (PC_W),
            .SETS (SETS),
            .IDX_W(IDX_W),
            .TAG_W(TAG_W)
        ) u_way (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .rd_idx   (rd_idx),
            .rd_tag   (rd_tag),
            .rd_match (rd_match[w]),
            .rd_ctr   (rd_ctr[w]),
            .rd_target(rd_target[w]),
            .up_idx   (up_idx),
            .up_tag   (up_tag),
            .up_match (up_match[w]),
            .up_valid (up_valid[w]),
            .up_ctr   (up_ctr[w]),
            .alloc    (alloc[w]),
            .ctr_we   (ctr_we[w]),
            .ctr_wdata(new_ctr),
            .tgt_we   (tgt_we[w]),
            .tgt_wdata(target_pc)
        );
    end

    always_comb begin
        hit_ctr   = CTR_MIN;
        alloc     = '0;
        ctr_we    = '0;
        tgt_we    = '0;
        victim    = '0;
        found_inv = 1'b0;
        ptr_d     = ptr_q;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (up_match[w]) hit_ctr = hit_ctr | up_ctr[w];
        end
        new_ctr = br_taken ? ctr_inc(hit_ctr) : ctr_dec(hit_ctr);
        // Descending scan leaves the lowest-index invalid way as the victim.
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!up_valid[w-1]) begin
                victim    = PTR_W'(w - 1);
                found_inv = 1'b1;
            end
        end
        if (flush) begin
            ptr_d = '0;
        end else if (up_ok) begin
            if (up_any) begin
                ctr_we = up_match;
                tgt_we = br_taken ? up_match : '0;
            end else if (br_taken) begin
                if (!found_inv) begin
                    victim        = ptr_q[up_idx];
                    ptr_d[up_idx] = (ptr_q[up_idx] == PTR_W'(WAYS - 1)) ? '0
                                  : ptr_q[up_idx] + 1'b1;
                end
                for (int unsigned w = 0; w < WAYS; w++) begin
                    alloc[w] = (victim == PTR_W'(w));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        ctr_t            sel_ctr;
        logic [PC_W-1:0] sel_tgt;
        sel_ctr = CTR_MIN;
        sel_tgt = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (rd_match[w]) begin
                sel_ctr = sel_ctr | rd_ctr[w];
                sel_tgt = sel_tgt | rd_target[w];
            end
        end
        hit            = (pc_in[1:0] == 2'b00) && (|rd_match);
        target_predict = hit ? sel_tgt : '0;
        predict_taken  = hit && sel_ctr[1];
`ifdef BTB_FWD_EN
        // Identical PC means the update hit way is the lookup hit way.
        if (up_ok && (pc_ex == pc_in)) begin
            if (up_any) begin
                hit            = 1'b1;
                target_predict = br_taken ? target_pc : sel_tgt;
                predict_taken  = new_ctr[1];
            end else if (br_taken) begin
                hit            = 1'b1;
                target_predict = target_pc;
                predict_taken  = CTR_ALLOC[1];
            end
        end
`endif
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios plus randomized traffic
// checked against a per-set/per-way behavioural table model.
module tb_btb_assoc;

    localparam int unsigned SETS = 64;
    localparam int unsigned WAYS = 4;

    logic        clk, rst_n, flush, br_update, br_taken;
    logic [31:0] pc_in, pc_ex, target_pc;
    logic        hit, predict_taken;
    logic [31:0] target_predict;

    int checks   = 0;
    int failures = 0;

    btb_assoc #(.PC_W(32), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .pc_in         (pc_in),
        .hit           (hit),
        .target_predict(target_predict),
        .predict_taken (predict_taken),
        .br_update     (br_update),
        .br_taken      (br_taken),
        .pc_ex         (pc_ex),
        .target_pc     (target_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bit          m_valid [SETS][WAYS];
    logic [23:0] m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int unsigned m_ctr   [SETS][WAYS];
    int unsigned m_rr    [SETS];

    function automatic void m_reset();
        for (int unsigned i = 0; i < SETS; i++) begin
            m_rr[i] = 0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                m_valid[i][w] = 1'b0;
                m_ctr[i][w]   = 0;
            end
        end
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int unsigned s = (pc >> 2) % SETS;
        m_find = -1;
        for (int unsigned w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc[31:8]) m_find = int'(w);
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic h,
                                     output logic [31:0] t, output logic p);
        int unsigned s = (pc >> 2) % SETS;
        int          f = m_find(pc);
        int unsigned c;
        h = 1'b0; t = '0; p = 1'b0;
        if (pc[1:0] != 2'b00) return;
        if (f >= 0) begin
            h = 1'b1; t = m_tgt[s][f]; p = (m_ctr[s][f] >= 2);
        end
`ifdef BTB_FWD_EN
        if (rst_n && br_update && !flush && pc_ex == pc) begin
            if (f >= 0) begin
                c = m_ctr[s][f];
                if (br_taken) begin c = (c < 3) ? c + 1 : 3; t = target_pc; end
                else c = (c > 0) ? c - 1 : 0;
                h = 1'b1; p = (c >= 2);
            end else if (br_taken) begin
                h = 1'b1; t = target_pc; p = 1'b1;
            end
        end
`else
        c = 0;
`endif
    endfunction

    function automatic void m_apply();
        int unsigned s = (pc_ex >> 2) % SETS;
        int          f = m_find(pc_ex);
        int unsigned v = WAYS;
        if (flush) begin
            for (int unsigned i = 0; i < SETS; i++) begin
                m_rr[i] = 0;
                for (int unsigned w = 0; w < WAYS; w++) m_valid[i][w] = 1'b0;
            end
            return;
        end
        if (!br_update || pc_ex[1:0] != 2'b00) return;
        if (f >= 0) begin
            if (br_taken) begin
                m_tgt[s][f] = target_pc;
                if (m_ctr[s][f] < 3) m_ctr[s][f]++;
            end else if (m_ctr[s][f] > 0) m_ctr[s][f]--;
        end else if (br_taken) begin
            for (int unsigned w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && v == WAYS) v = w;
            if (v == WAYS) begin
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = pc_ex[31:8];
            m_tgt[s][v]   = target_pc;
            m_ctr[s][v]   = 2;
        end
    endfunction

    task automatic drive(input logic upd, input logic tk, input logic [31:0] pex,
                         input logic [31:0] tgt, input logic [31:0] pin, input logic fl);
        br_update = upd; br_taken = tk; pc_ex = pex; target_pc = tgt;
        pc_in = pin; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_apply();
        #1;
    endtask

    task automatic test_reset();
        logic eh, ep; logic [31:0] et;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0);
        m_reset();
        #12;
        m_lookup(pc_in, eh, et, ep);
        checks++;
        if ({hit, predict_taken, target_predict} !== {1'b0, 1'b0, 32'h0} ||
            {eh, ep, et} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_outputs got hit=%0b tk=%0b tgt=%h exp 0 0 0",
                     hit, predict_taken, target_predict);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_counter();
        logic eh, ep; logic [31:0] et;
        logic [2:0] seq [10] = '{3'b110, 3'b000, 3'b100, 3'b100, 3'b000,
                                3'b110, 3'b110, 3'b110, 3'b110, 3'b100};
        logic [2:0] op;
        for (int i = 0; i < 10; i++) begin
            op = seq[i];
            drive(op[2], op[1], 32'h100, 32'h200, 32'h100, 1'b0);
            #1;
            m_lookup(pc_in, eh, et, ep);
            checks++;
            if ({hit, predict_taken, target_predict} !== {eh, ep, et}) begin
                failures++;
                $display("FAIL counter_step%0d got hit=%0b tk=%0b tgt=%h exp hit=%0b tk=%0b tgt=%h",
                         i, hit, predict_taken, target_predict, eh, ep, et);
            end
            tick();
            if (i == 0 || i == 4 || i == 9) begin
                drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0);
                #1;
                checks++;
                if ({hit, predict_taken, target_predict} !==
                    {1'b1, (i != 4), 32'h200}) begin
                    failures++;
                    $display("FAIL counter_after%0d got hit=%0b tk=%0b tgt=%h exp hit=1 tk=%0b tgt=200",
                             i, hit, predict_taken, target_predict, (i != 4));
                end
            end
        end
    endtask

    task automatic test_eviction();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b1, 32'(k << 8), 32'h1000 + 32'(k), 32'h0, 1'b0);
            tick();
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 32'(k << 8), 1'b0);
            #1;
            checks++;
            if ({hit, target_predict} !== ((k == 1) ? {1'b0, 32'h0} : {1'b1, 32'h1000 + 32'(k)})) begin
                failures++;
                $display("FAIL evict_pc%0d got hit=%0b tgt=%h", k, hit, target_predict);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 32'h300, 32'h3333, 32'h700, 1'b1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 32'(k << 8), 1'b0);
            #1;
            checks++;
            if (hit !== 1'b0) begin
                failures++;
                $display("FAIL flush_pc%0d got hit=%0b exp 0", k, hit);
            end
            tick();
        end
    endtask

    task automatic test_forward();
        logic [32:0] exp_now;
`ifdef BTB_FWD_EN
        exp_now = {1'b1, 32'h480};
`else
        exp_now = {1'b0, 32'h0};
`endif
        drive(1'b1, 1'b1, 32'h400, 32'h480, 32'h400, 1'b0);
        #1;
        checks++;
        if ({hit, target_predict} !== exp_now) begin
            failures++;
            $display("FAIL fwd_same_cycle got hit=%0b tgt=%h exp %h", hit, target_predict, exp_now);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h400, 1'b0);
        #1;
        checks++;
        if ({hit, predict_taken, target_predict} !== {1'b1, 1'b1, 32'h480}) begin
            failures++;
            $display("FAIL fwd_next_cycle got hit=%0b tk=%0b tgt=%h exp 1 1 480",
                     hit, predict_taken, target_predict);
        end
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] pcs  [3] = '{32'h600, 32'h402, 32'h400};
        logic        exph [3] = '{1'b0, 1'b0, 1'b1};
        drive(1'b1, 1'b1, 32'h602, 32'h700, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, pcs[i], 1'b0);
            #1;
            checks++;
            if (hit !== exph[i]) begin
                failures++;
                $display("FAIL misaligned_%0d got hit=%0b exp %0b", i, hit, exph[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic eh, ep; logic [31:0] et, pe, pi;
        for (int i = 0; i < 600; i++) begin
            pe = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 15) == 0) pe = pe | 32'h2;
            pi = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 2) == 0) pi = pe;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, pe,
                  $urandom & 32'hFFFF_FFFC, pi, $urandom_range(0, 49) == 0);
            #1;
            m_lookup(pc_in, eh, et, ep);
            checks++;
            if ({hit, predict_taken, target_predict} !== {eh, ep, et}) begin
                failures++;
                $display("FAIL random_%0d pc=%h got hit=%0b tk=%0b tgt=%h exp hit=%0b tk=%0b tgt=%h",
                         i, pc_in, hit, predict_taken, target_predict, eh, ep, et);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 32'h100, 32'h250, 32'h100, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({hit, predict_taken, target_predict} !== {1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL async_reset got hit=%0b tk=%0b tgt=%h exp 0 0 0",
                     hit, predict_taken, target_predict);
        end
        drive(1'b1, 1'b1, 32'h100, 32'h999, 32'h100, 1'b0);
        tick();
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h100, 32'h204, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0);
        #1;
        checks++;
        if ({hit, predict_taken, target_predict} !== {1'b1, 1'b1, 32'h204}) begin
            failures++;
            $display("FAIL first_update_after_reset got hit=%0b tk=%0b tgt=%h exp 1 1 204",
                     hit, predict_taken, target_predict);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_counter();
        test_eviction();
        test_flush();
        test_forward();
        test_misaligned();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
